// File: rtl/i2c_passthru_sda_driver.sv
// i2c_passthru_sda_driver
// Timed open-drain driver for one passthru SDA/SCL line. A requester asks
// for a line level over a ready/req handshake. The block drives the pad,
// waits up to F_REF_T_R reference ticks for the pad input to follow, and
// then holds the level for F_REF_T_HOLD ticks before it reports done.
// If the pad disagrees with what is driven, the line is released and the
// block reports arbitration loss (released high, read low) or a stuck bus
// (driven low, read high).
// All timing is counted in rising edges of the slow reference i_f_ref,
// observed in the i_clk domain.

`timescale 1ns/1ps

module i2c_passthru_sda_driver #(
  parameter int F_REF_T_R    = 15,  // max ticks for the pad to follow (>= 2)
  parameter int F_REF_T_HOLD = 8,   // ticks the level is held once seen (>= 1)
  parameter int WIDTH_F_REF  = 4    // timer width, fits max(T_R, T_HOLD)
) (
  input  logic i_clk,
  input  logic rstn,
  input  logic i_f_ref,
  input  logic i_req,
  input  logic i_level,
  input  logic i_padin_sig,
  output logic o_padout_sig,
  output logic o_ready,
  output logic o_done,
  output logic o_arb_lost,
  output logic o_stuck
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_HOLD   = 3'd2,
    S_DONE   = 3'd3,
    S_LOST   = 3'd4,
    S_STUCK  = 3'd5
  } state_t;

  localparam logic [WIDTH_F_REF-1:0] T_R_LOAD    = WIDTH_F_REF'(F_REF_T_R);
  localparam logic [WIDTH_F_REF-1:0] T_HOLD_LOAD = WIDTH_F_REF'(F_REF_T_HOLD);

  state_t                 state;
  logic [WIDTH_F_REF-1:0] timer;
  logic                   prev_f_ref;

  logic                   tick;
  logic                   pad_match;
  logic                   timer_zero;
  logic [WIDTH_F_REF-1:0] timer_dec;

  // One timer tick per 0->1 edge of the reference as seen at i_clk.
  assign tick       = ~prev_f_ref & i_f_ref;
  assign pad_match  = (i_padin_sig == o_padout_sig);
  assign timer_zero = (timer == '0);
  // Saturating decrement: the timer parks at zero and never wraps.
  assign timer_dec  = (tick && !timer_zero) ? timer - 1'b1 : timer;

  // Moore outputs decoded straight from the state register, so they are
  // glitch-free and change only on clock edges.
  assign o_ready    = (state == S_IDLE);
  assign o_done     = (state == S_DONE);
  assign o_arb_lost = (state == S_LOST);
  assign o_stuck    = (state == S_STUCK);

  // Handshake, settle/hold timing and fault detection in one registered FSM.
  always_ff @(posedge i_clk) begin
    // NOTE: reset here is synchronous (sampled on the clock edge), so rstn
    // sits inside the clocked branch rather than in the sensitivity list.
    if (!rstn) begin
      state        <= S_IDLE;
      o_padout_sig <= 1'b1;
      timer        <= T_R_LOAD;
      prev_f_ref   <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every branch
      // below reads the pre-edge values of state, timer and o_padout_sig.
      prev_f_ref <= i_f_ref;

      case (state)
        // Accept a request; i_level is sampled only on this edge.
        S_IDLE: begin
          if (i_req) begin
            o_padout_sig <= i_level;
            timer        <= T_R_LOAD;
            state        <= S_SETTLE;
          end
        end

        // Wait for the pad to follow; a match beats a same-cycle timeout.
        S_SETTLE: begin
          if (pad_match) begin
            timer <= T_HOLD_LOAD;
            state <= S_HOLD;
          end else if (timer_zero && o_padout_sig) begin
            // Released but still read low: another master owns the line.
            state <= S_LOST;
          end else if (timer_zero) begin
            // Driven low but never read low: release and flag it.
            o_padout_sig <= 1'b1;
            state        <= S_STUCK;
          end else begin
            timer <= timer_dec;
          end
        end

        // Keep the level for the hold time; any disagreement aborts.
        S_HOLD: begin
          if (!pad_match) begin
            o_padout_sig <= 1'b1;
            state        <= o_padout_sig ? S_LOST : S_STUCK;
          end else if (timer_zero) begin
            state <= S_DONE;
          end else begin
            timer <= timer_dec;
          end
        end

        // Success: a driven-low level stays driven until the next request.
        S_DONE: begin
          state <= S_IDLE;
        end

        // Faults leave the line released.
        S_LOST, S_STUCK: begin
          o_padout_sig <= 1'b1;
          state        <= S_IDLE;
        end

        // Unreachable encodings recover to a released, idle line.
        default: begin
          o_padout_sig <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_passthru_sda_driver.sv
// tb_i2c_passthru_sda_driver
// Directed bench for the timed open-drain SDA driver. The reference runs at
// clk/4, so there is one tick every 4 clocks. A small bus model either
// follows the pad output three clocks later or forces the pad high or low.
// Expected completion events are queued as the requests are issued. They
// are popped and compared when the DUT pulses done, arb_lost or stuck.

`timescale 1ns/1ps

module tb_i2c_passthru_sda_driver;

  localparam int T_R    = 15;
  localparam int T_HOLD = 8;

  typedef enum int {PAD_FOLLOW, PAD_HIGH, PAD_LOW} pad_mode_t;
  typedef enum int {EV_DONE, EV_LOST, EV_STUCK} ev_t;

  typedef struct {
    ev_t  kind;
    int   lo;     // earliest clock edge (cyc) the pulse may appear on
    int   hi;     // latest clock edge
    logic pad;    // required o_padout_sig during and after the pulse
  } exp_t;

  logic i_clk = 1'b0;
  logic rstn;
  logic i_f_ref;
  logic i_req;
  logic i_level;
  logic i_padin_sig;
  logic o_padout_sig;
  logic o_ready;
  logic o_done;
  logic o_arb_lost;
  logic o_stuck;

  int        n_assert = 0;
  int        n_fail   = 0;
  int        cyc      = 0;
  int        tick_cnt = 0;
  int        phase    = 0;
  logic      f_ref_last = 1'b0;
  logic [2:0] dly     = 3'b111;
  pad_mode_t pad_mode = PAD_FOLLOW;
  exp_t      sb[$];

  i2c_passthru_sda_driver #(
    .F_REF_T_R   (T_R),
    .F_REF_T_HOLD(T_HOLD),
    .WIDTH_F_REF (4)
  ) dut (
    .i_clk       (i_clk),
    .rstn        (rstn),
    .i_f_ref     (i_f_ref),
    .i_req       (i_req),
    .i_level     (i_level),
    .i_padin_sig (i_padin_sig),
    .o_padout_sig(o_padout_sig),
    .o_ready     (o_ready),
    .o_done      (o_done),
    .o_arb_lost  (o_arb_lost),
    .o_stuck     (o_stuck)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int val, input int lo, input int hi);
    n_assert++;
    assert (val >= lo && val <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic apply_pad();
    case (pad_mode)
      PAD_HIGH: i_padin_sig = 1'b1;
      PAD_LOW:  i_padin_sig = 1'b0;
      default:  i_padin_sig = dly[2];
    endcase
  endtask

  // Advance one clock: account the edge just taken, then drive inputs.
  task automatic step();
    @(negedge i_clk);
    cyc++;
    if (i_f_ref && !f_ref_last) tick_cnt++;
    f_ref_last = i_f_ref;
    phase      = (phase + 1) % 4;
    i_f_ref    = (phase >= 2);
    dly        = {dly[1:0], o_padout_sig};
    apply_pad();
  endtask

  function automatic logic [2:0] ev_vec(input ev_t k);
    case (k)
      EV_DONE: return 3'b100;
      EV_LOST: return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Wait (bounded) for the next pulse and compare it with the queue head.
  task automatic wait_event(input string tag, input int budget);
    exp_t e;
    bit   seen = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (o_done || o_arb_lost || o_stuck) seen = 1'b1;
    end
    check({tag, "_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_kind"}, {o_done, o_arb_lost, o_stuck}, ev_vec(e.kind));
      check_range({tag, "_time"}, cyc, e.lo, e.hi);
      check({tag, "_pad"}, o_padout_sig, e.pad);
      check({tag, "_busy"}, o_ready, 0);
      step();
      check({tag, "_one_cycle"}, {o_done, o_arb_lost, o_stuck}, 0);
      check({tag, "_ready_after"}, o_ready, 1);
      check({tag, "_pad_after"}, o_padout_sig, e.pad);
    end
  endtask

  // Issue a one-cycle request; returns the accepting edge number.
  task automatic request(input logic level, output int acc);
    i_req   = 1'b1;
    i_level = level;
    acc     = cyc + 1;
    step();
    i_req   = 1'b0;
    i_level = 1'b1;
  endtask

  initial begin
    int acc;
    int t0;
    int accepts;
    int dones;
    logic exp_pad;
    logic lvl;
    logic was_ready;

    rstn    = 1'b0;
    i_req   = 1'b0;
    i_level = 1'b1;
    i_f_ref = 1'b0;
    apply_pad();

    // Reset state.
    repeat (3) step();
    check("rst_pad", o_padout_sig, 1);
    check("rst_ready", o_ready, 1);
    check("rst_pulses", {o_done, o_arb_lost, o_stuck}, 0);
    rstn = 1'b1;
    step();
    check("post_rst_ready", o_ready, 1);
    check("post_rst_pad", o_padout_sig, 1);

    // Drive low, bus follows 3 clocks later: done after the hold time.
    request(1'b0, acc);
    check("drive_low_pad", o_padout_sig, 0);
    check("drive_low_ready", o_ready, 0);
    sb.push_back('{EV_DONE, acc + 31, acc + 38, 1'b0});
    wait_event("drive_low", 80);

    // Drive low with the pad held high: stuck after T_R ticks.
    pad_mode = PAD_HIGH;
    apply_pad();
    request(1'b0, acc);
    check("stuck_pad_driven", o_padout_sig, 0);
    sb.push_back('{EV_STUCK, acc + 56, acc + 64, 1'b1});
    wait_event("stuck", 100);

    // Release with another master holding the pad low: arb lost at T_R.
    pad_mode = PAD_LOW;
    apply_pad();
    request(1'b1, acc);
    check("lost_settle_pad", o_padout_sig, 1);
    sb.push_back('{EV_LOST, acc + 56, acc + 64, 1'b1});
    wait_event("lost_settle", 100);

    // Release succeeds, then the pad is pulled low at tick 4 of HOLD.
    pad_mode = PAD_FOLLOW;
    repeat (4) step();
    request(1'b1, acc);
    step();
    t0 = tick_cnt;
    for (int i = 0; i < 40 && tick_cnt < t0 + 4; i++) step();
    check("lost_hold_no_early", {o_done, o_arb_lost, o_stuck}, 0);
    pad_mode = PAD_LOW;
    apply_pad();
    sb.push_back('{EV_LOST, cyc + 1, cyc + 1, 1'b1});
    wait_event("lost_hold", 10);

    // Pad matches on the exact cycle the SETTLE timer sits at zero.
    pad_mode = PAD_HIGH;
    apply_pad();
    request(1'b0, acc);
    t0 = tick_cnt;
    for (int i = 0; i < 90 && tick_cnt < t0 + T_R; i++) step();
    check("edge_no_early", {o_done, o_arb_lost, o_stuck}, 0);
    check("edge_pad_driven", o_padout_sig, 0);
    pad_mode = PAD_LOW;
    apply_pad();
    sb.push_back('{EV_DONE, cyc + 29, cyc + 36, 1'b0});
    wait_event("edge_match", 60);

    // Reset during HOLD while driving low releases the line at once.
    pad_mode = PAD_FOLLOW;
    repeat (4) step();
    request(1'b0, acc);
    repeat (10) step();
    check("hold_rst_pre_pad", o_padout_sig, 0);
    check("hold_rst_pre_ready", o_ready, 0);
    rstn = 1'b0;
    step();
    check("hold_rst_pad", o_padout_sig, 1);
    check("hold_rst_ready", o_ready, 1);
    check("hold_rst_pulses", {o_done, o_arb_lost, o_stuck}, 0);
    rstn = 1'b1;
    repeat (4) step();

    // i_req held high with alternating level: one acceptance per window,
    // and the pad moves only on accepting edges.
    accepts = 0;
    dones   = 0;
    exp_pad = 1'b1;
    i_req   = 1'b1;
    i_level = 1'b0;
    for (int i = 0; i < 200; i++) begin
      lvl       = i_level;
      was_ready = o_ready;
      step();
      if (was_ready) begin
        accepts++;
        exp_pad = lvl;
        check("cont_accept_ready", o_ready, 0);
      end
      check("cont_pad", o_padout_sig, exp_pad);
      check("cont_no_fault", {o_arb_lost, o_stuck}, 0);
      if (o_done) dones++;
      i_level = ~i_level;
    end
    i_req = 1'b0;
    check("cont_accepts", accepts >= 3, 1);
    check("cont_dones", (dones == accepts) || (dones == accepts - 1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_passthru_sda_driver.md
Name: i2c_passthru_sda_driver

Overview:
Timed open-drain driver for one passthru SDA/SCL line, producing the pad output that the mismatch checker monitors. A requester asks for a line level through a ready/req handshake. The block drives the pad, then waits up to t_r (in i_f_ref periods) for the pad input to follow. It holds the level for a minimum time, then reports done. If the bus does not follow, it releases the line and reports arbitration loss or a stuck bus.

Parameters:
F_REF_T_R, 15, max i_f_ref rising edges allowed for pad input to follow pad output (t_r timeout); >=2
F_REF_T_HOLD, 8, i_f_ref rising edges the level must be held after it is seen on the pad; >=1
WIDTH_F_REF, 4, timer width; >= ceil(log2(max(F_REF_T_R,F_REF_T_HOLD)+1))

Ports:
i_clk  in  1  system clock
rstn  in  1  synchronous active-low reset (sampled on posedge i_clk)
i_f_ref  in  1  slow reference; each 0->1 edge seen at i_clk is one timer tick
i_req  in  1  request a new level; accepted only when o_ready=1
i_level  in  1  requested level: 1=release (high-Z), 0=drive low
i_padin_sig  in  1  pad input, already synchronized to i_clk
o_padout_sig  out  1  registered pad output: 0=drive low, 1=release
o_ready  out  1  block idle, can accept i_req
o_done  out  1  one-cycle pulse: level driven, seen, and held
o_arb_lost  out  1  one-cycle pulse: released high but pad read low (other master)
o_stuck  out  1  one-cycle pulse: drove low but pad stayed high past t_r

Behaviour:
- Reset (rstn=0 at posedge) sets: state=IDLE, o_padout_sig=1, timer=F_REF_T_R, prev_f_ref=0, and all pulses 0. o_ready=1 from the first cycle after reset. Reset mid-operation aborts the operation and releases the line on that same clock edge.
- tick = ~prev_f_ref & i_f_ref. prev_f_ref is registered every cycle.
- The timer decrements only on a tick and saturates at 0, with no wrap.
- Moore outputs are decoded from state: o_ready=(IDLE), o_done=(DONE), o_arb_lost=(LOST), o_stuck=(STUCK).
- IDLE:
  - On i_req=1: o_padout_sig<=i_level, timer<=F_REF_T_R, next state SETTLE.
  - The accepting edge is also the edge where o_ready deasserts. The request-to-pad latency is 1 cycle.
  - i_req is ignored in every state except IDLE. i_level is sampled only on the accepting cycle.
- SETTLE, evaluated each cycle in priority order:
  - (1) i_padin_sig==o_padout_sig: timer<=F_REF_T_HOLD, next state HOLD. Match wins over a timeout in the same cycle.
  - (2) timer==0 and o_padout_sig==1: next state LOST.
  - (3) timer==0 and o_padout_sig==0: o_padout_sig<=1, next state STUCK.
  - (4) otherwise decrement on tick.
- HOLD:
  - i_padin_sig!=o_padout_sig: o_padout_sig<=1, next state LOST (when o_padout_sig=1), or STUCK (when o_padout_sig=0, i.e. the line rose while driven low).
  - Else timer==0: next state DONE.
  - Else decrement on tick.
- DONE, LOST, STUCK:
  - Each lasts exactly one cycle, then returns to IDLE.
  - o_padout_sig keeps its value in DONE, so a driven-low level stays driven until the next request.
  - o_padout_sig=1 in LOST and STUCK.
- A request whose level equals the current pad level still passes through SETTLE and HOLD. SETTLE exits after 1 cycle because the match is already present.
- Minimum request-to-done time is 1 + 1 + (F_REF_T_HOLD ticks) + 1 cycles. Maximum time to a fault is bounded by F_REF_T_R ticks plus 2 cycles.
- Unused state encodings go to IDLE, with o_padout_sig<=1.

Test Plan:
- Reset with i_f_ref=clk/4 (tick every 4 clk) -> o_padout_sig=1, o_ready=1, all pulses 0. Reset during HOLD with drive low -> o_padout_sig=1 and o_ready=1 on the next cycle.
- Drive low, bus model follows after 3 clk -> o_padout_sig=0 one cycle after req. HOLD lasts 8 ticks (32 clk ±4). o_done pulses once, o_padout_sig stays 0, o_ready returns.
- Drive low, pad held high -> after 15 ticks (60 clk ±4) o_stuck pulses 1 cycle and o_padout_sig returns to 1. o_done never asserts.
- Release, other master holds pad low -> o_arb_lost pulses after 15 ticks. Separately, release succeeds, then pad pulled low at tick 4 of HOLD -> o_arb_lost on the next cycle.
- Pad matches in the exact cycle the timer hits 0 in SETTLE -> enters HOLD, no fault pulse.
- i_req held high continuously, alternating i_level -> only one acceptance per o_ready window. Requests during SETTLE/HOLD are ignored, and o_padout_sig changes only on accepting edges or faults.
